// File: rtl/hello_uart_tx.sv
// Transmits the fixed message "hello world\r\n" once per accepted start, framed 8N1.
// Characters go out back-to-back; done pulses for one cycle as the block returns to idle.
module hello_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [3:0] char_idx,
  output logic [1:0] dbg_state_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_CHAR = 4'd12;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [3:0]       char_q;
  logic [7:0]       byte_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;
  logic             bit_end;
  logic [3:0]       char_d;

  function automatic logic [7:0] msg_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    msg_rom = 8'h68;
      4'd1:    msg_rom = 8'h65;
      4'd2:    msg_rom = 8'h6C;
      4'd3:    msg_rom = 8'h6C;
      4'd4:    msg_rom = 8'h6F;
      4'd5:    msg_rom = 8'h20;
      4'd6:    msg_rom = 8'h77;
      4'd7:    msg_rom = 8'h6F;
      4'd8:    msg_rom = 8'h72;
      4'd9:    msg_rom = 8'h6C;
      4'd10:   msg_rom = 8'h64;
      4'd11:   msg_rom = 8'h0D;
      4'd12:   msg_rom = 8'h0A;
      default: msg_rom = 8'h00;
    endcase
  endfunction

  assign bit_end = (baud_q == BIT_LAST);
  assign char_d  = char_q + 4'd1;

  // tx_q always holds the level of the bit being sent, so the line comes straight off a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      char_q  <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) begin
        baud_q <= bit_end ? '0 : baud_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          if (start) begin
            state_q <= START;
            char_q  <= '0;
            byte_q  <= msg_rom(4'd0);
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            bit_q   <= '0;
            tx_q    <= byte_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= byte_q[bit_q + 3'd1];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (char_q < LAST_CHAR) begin
              state_q <= START;
              char_q  <= char_d;
              byte_q  <= msg_rom(char_d);
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              char_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign char_idx    = char_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hello_uart_tx.sv
// Bench for hello_uart_tx at CLKS_PER_BIT=4: cycle-exact line model plus a UART
// decoder that pops expected bytes from a queue filled when each message is launched.
module tb_hello_uart_tx;

  localparam int CPB      = 4;
  localparam int CHAR_CYC = 10 * CPB;
  localparam int MSG_CYC  = 13 * CHAR_CYC;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       tx;
  logic       busy;
  logic       done;
  logic [3:0] char_idx;
  logic [1:0] dbg_state;

  logic [7:0] msg [0:12] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77,
                             8'h6F, 8'h72, 8'h6C, 8'h64, 8'h0D, 8'h0A};

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  hello_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .tx          (tx),
    .busy        (busy),
    .done        (done),
    .char_idx    (char_idx),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_tx(input int k);
    int c;
    int b;
    logic [7:0] ch;
    c  = k / CHAR_CYC;
    b  = (k % CHAR_CYC) / CPB;
    ch = msg[c];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return ch[b-1];
  endfunction

  task automatic push_msg();
    for (int i = 0; i < 13; i++) exp_q.push_back(msg[i]);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"}, tx, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_char_idx"}, char_idx, 4'd0);
  endtask

  // Called one cycle after the start-sampling edge; returns in the done cycle,
  // or right after an injected reset when abort_at >= 0.
  task automatic observe_msg(input int abort_at, input bit pulses);
    for (int k = 0; k < MSG_CYC; k++) begin
      if (k == abort_at) begin
        rst_n = 1'b0;
        start = 1'b1;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        check_idle("abort");
        for (int i = 0; i < 10; i++) begin
          tick();
          check_idle("after_abort");
        end
        return;
      end
      check("tx", tx, exp_tx(k));
      check("busy", busy, 1'b1);
      check("done_early", done, 1'b0);
      check("char_idx", char_idx, k / CHAR_CYC);
      if (pulses && (k == 100 || k == 300)) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end else begin
        tick();
      end
    end
    check("done_pulse", done, 1'b1);
    check("done_busy", busy, 1'b0);
    check("done_tx", tx, 1'b1);
    check("done_char_idx", char_idx, 4'd0);
  endtask

  task automatic pulse_start();
    push_msg();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // UART decoder / scoreboard monitor
  int         mon_cyc;
  bit         mon_active = 1'b0;
  bit         glitch;
  logic       bit_val;
  logic [7:0] mon_byte;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cyc    = 1;
        bit_val    = 1'b0;
        glitch     = 1'b0;
      end
    end else begin
      if (mon_cyc % CPB == 0) bit_val = tx;
      else if (tx !== bit_val) glitch = 1'b1;
      if (mon_cyc % CPB == CPB - 1) begin
        if (mon_cyc / CPB >= 1 && mon_cyc / CPB <= 8) mon_byte[mon_cyc / CPB - 1] = bit_val;
        if (mon_cyc / CPB == 9) begin
          check("frame", {30'd0, glitch, bit_val}, 32'd1);
          check("byte_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) check("byte", mon_byte, exp_q.pop_front());
          mon_active = 1'b0;
        end
      end
      mon_cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // directed driver
  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    check_idle("reset");
    start = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_idle("idle");
    end

    // single message
    pulse_start();
    observe_msg(-1, 1'b0);
    tick();
    check_idle("post_msg");

    // starts during a message are dropped
    pulse_start();
    observe_msg(-1, 1'b1);
    tick();
    check_idle("post_ignored");

    // reset during character 5, then a fresh full message
    pulse_start();
    observe_msg(5 * CHAR_CYC + 10, 1'b0);
    pulse_start();
    observe_msg(-1, 1'b0);
    tick();
    check_idle("post_reset_msg");

    // held start: the done cycle is the only cycle between messages
    push_msg();
    start = 1'b1;
    tick();
    observe_msg(-1, 1'b0);
    push_msg();
    tick();
    check("restart_tx", tx, 1'b0);
    check("restart_busy", busy, 1'b1);
    observe_msg(-1, 1'b0);
    start = 1'b0;
    tick();
    check_idle("post_held");

    for (int i = 0; i < 5; i++) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
